// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the shared memory port.
// The arbiter uses the slave modport; requesters and the memory use the master modport.
interface mem_port_arbiter_if;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  logic              i_if_req;
  logic [ADDR_W-1:0] i_if_addr;
  logic              o_if_gnt;
  logic              o_if_rvalid;
  logic [DATA_W-1:0] o_if_rdata;

  logic              i_d_req;
  logic              i_d_wen;
  logic [ADDR_W-1:0] i_d_addr;
  logic [DATA_W-1:0] i_d_wdata;
  logic [MASK_W-1:0] i_d_mask;
  logic              o_d_gnt;
  logic              o_d_rvalid;
  logic [DATA_W-1:0] o_d_rdata;

  logic [ADDR_W-1:0] o_mem_addr;
  logic              o_mem_ren;
  logic              o_mem_wen;
  logic [DATA_W-1:0] o_mem_wdata;
  logic [MASK_W-1:0] o_mem_mask;
  logic [DATA_W-1:0] i_mem_rdata;

  modport slave (
    input  i_if_req, i_if_addr,
    output o_if_gnt, o_if_rvalid, o_if_rdata,
    input  i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    output o_d_gnt, o_d_rvalid, o_d_rdata,
    output o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    input  i_mem_rdata
  );

  modport master (
    output i_if_req, i_if_addr,
    input  o_if_gnt, o_if_rvalid, o_if_rdata,
    output i_d_req, i_d_wen, i_d_addr, i_d_wdata, i_d_mask,
    input  o_d_gnt, o_d_rvalid, o_d_rdata,
    input  o_mem_addr, o_mem_ren, o_mem_wen, o_mem_wdata, o_mem_mask,
    output i_mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port sync memory between instruction fetch and data access; data wins by default.
// Define ARB_STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT consecutive denied fetch cycles.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  mem_port_arbiter_if.slave bus
);
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;

  typedef enum logic [1:0] {IDLE, IF_RD, D_RD} state_t;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_limit
    $error("STARVE_LIMIT must be within 1..15");
  end

  state_t state_q;
  state_t state_d;
  logic   if_gnt_c;
  logic   d_gnt_c;
  logic   force_if_c;

`ifdef ARB_STARVE_GUARD_EN
  localparam int unsigned CNT_W = 4;
  logic [CNT_W-1:0] starve_q;

  assign force_if_c = (starve_q == CNT_W'(STARVE_LIMIT)) && bus.i_if_req && bus.i_d_req;

  // Counts consecutive denied fetch cycles; any fetch grant or idle fetch clears it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      starve_q <= '0;
    end else if (bus.i_if_req && !if_gnt_c) begin
      if (starve_q != CNT_W'(STARVE_LIMIT)) starve_q <= starve_q + CNT_W'(1);
    end else begin
      starve_q <= '0;
    end
  end
`else
  assign force_if_c = 1'b0;
`endif

  // Grants are held low during reset regardless of requests
  assign if_gnt_c = i_rst_n && bus.i_if_req && (!bus.i_d_req || force_if_c);
  assign d_gnt_c  = i_rst_n && bus.i_d_req && !force_if_c;

  assign bus.o_if_gnt = if_gnt_c;
  assign bus.o_d_gnt  = d_gnt_c;

  // Memory port mirrors the winner; word-aligned address, zeros when idle
  always_comb begin
    bus.o_mem_addr  = '0;
    bus.o_mem_ren   = 1'b0;
    bus.o_mem_wen   = 1'b0;
    bus.o_mem_wdata = '0;
    bus.o_mem_mask  = '0;
    if (if_gnt_c) begin
      bus.o_mem_addr = {bus.i_if_addr[ADDR_W-1:2], 2'b00};
      bus.o_mem_ren  = 1'b1;
    end else if (d_gnt_c) begin
      bus.o_mem_addr  = {bus.i_d_addr[ADDR_W-1:2], 2'b00};
      bus.o_mem_ren   = !bus.i_d_wen;
      bus.o_mem_wen   = bus.i_d_wen;
      bus.o_mem_wdata = bus.i_d_wdata;
      bus.o_mem_mask  = MASK_W'(bus.i_d_mask);
    end
  end

  always_comb begin
    state_d = IDLE;
    if (if_gnt_c)                   state_d = IF_RD;
    else if (d_gnt_c && !bus.i_d_wen) state_d = D_RD;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Read data belongs to whoever was granted a read last cycle
  assign bus.o_if_rvalid = (state_q == IF_RD);
  assign bus.o_d_rvalid  = (state_q == D_RD);
  assign bus.o_if_rdata  = (state_q == IF_RD) ? bus.i_mem_rdata : DATA_W'(0);
  assign bus.o_d_rdata   = (state_q == D_RD)  ? bus.i_mem_rdata : DATA_W'(0);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small behavioural single-port memory.
// Covers both builds of ARB_STARVE_GUARD_EN (STARVE_LIMIT left at 4).
module tb_mem_port_arbiter;
  logic i_clk = 1'b0;
  logic i_rst_n;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [256];

  mem_port_arbiter_if bus ();

  mem_port_arbiter #(.STARVE_LIMIT(4)) dut (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .bus    (bus)
  );

  always #5 i_clk = ~i_clk;

  // Behavioural memory: byte-masked writes, 1-cycle read latency
  always @(posedge i_clk) begin
    if (bus.o_mem_wen) begin
      for (int b = 0; b < 4; b++)
        if (bus.o_mem_mask[b]) mem[bus.o_mem_addr[9:2]][b*8 +: 8] <= bus.o_mem_wdata[b*8 +: 8];
    end
    if (bus.o_mem_ren) bus.i_mem_rdata <= mem[bus.o_mem_addr[9:2]];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive request inputs shortly after the active edge, then let combinational outputs settle
  task automatic drive(input logic if_req, input logic [31:0] if_addr, input logic d_req,
                       input logic wen, input logic [31:0] d_addr, input logic [31:0] wdata,
                       input logic [3:0] mask);
    bus.i_if_req  = if_req;
    bus.i_if_addr = if_addr;
    bus.i_d_req   = d_req;
    bus.i_d_wen   = wen;
    bus.i_d_addr  = d_addr;
    bus.i_d_wdata = wdata;
    bus.i_d_mask  = mask;
    #1;
  endtask

  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    mem[0]    = 32'h0000_0013;
    mem[1]    = 32'h0000_0093;
    mem[2]    = 32'h0000_0113;
    mem[4]    = 32'h00A0_0093;
    mem[8'h80] = 32'hCAFE_0200;
    bus.i_mem_rdata = 32'h0;

    // Reset: requests present but everything must stay low
    i_rst_n = 1'b0;
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    check_eq("rst_if_gnt", 32'(bus.o_if_gnt), 32'h0);
    check_eq("rst_d_gnt", 32'(bus.o_d_gnt), 32'h0);
    check_eq("rst_ren", 32'(bus.o_mem_ren), 32'h0);
    check_eq("rst_wen", 32'(bus.o_mem_wen), 32'h0);
    check_eq("rst_if_rvalid", 32'(bus.o_if_rvalid), 32'h0);
    check_eq("rst_d_rvalid", 32'(bus.o_d_rvalid), 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #2 i_rst_n = 1'b1;
    next_cycle();

    // Fetch-only stream
    drive(1'b1, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("f0_gnt", 32'(bus.o_if_gnt), 32'h1);
    check_eq("f0_d_gnt", 32'(bus.o_d_gnt), 32'h0);
    check_eq("f0_addr", bus.o_mem_addr, 32'h0);
    check_eq("f0_ren", 32'(bus.o_mem_ren), 32'h1);
    next_cycle();
    drive(1'b1, 32'h4, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("f1_gnt", 32'(bus.o_if_gnt), 32'h1);
    check_eq("f1_addr", bus.o_mem_addr, 32'h4);
    check_eq("f0_rvalid", 32'(bus.o_if_rvalid), 32'h1);
    check_eq("f0_rdata", bus.o_if_rdata, 32'h13);
    check_eq("f0_d_rvalid", 32'(bus.o_d_rvalid), 32'h0);
    next_cycle();
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("f2_gnt", 32'(bus.o_if_gnt), 32'h1);
    check_eq("f1_rdata", bus.o_if_rdata, 32'h93);
    check_eq("f1_d_rvalid", 32'(bus.o_d_rvalid), 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("f2_rvalid", 32'(bus.o_if_rvalid), 32'h1);
    check_eq("f2_rdata", bus.o_if_rdata, 32'h113);
    check_eq("idle_addr", bus.o_mem_addr, 32'h0);
    check_eq("idle_ren", 32'(bus.o_mem_ren), 32'h0);
    next_cycle();
    check_eq("idle_if_rvalid", 32'(bus.o_if_rvalid), 32'h0);
    check_eq("idle_if_rdata", bus.o_if_rdata, 32'h0);

    // Contention: data read wins, fetch follows next cycle
    drive(1'b1, 32'h10, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    check_eq("c_d_gnt", 32'(bus.o_d_gnt), 32'h1);
    check_eq("c_if_gnt", 32'(bus.o_if_gnt), 32'h0);
    check_eq("c_addr", bus.o_mem_addr, 32'h200);
    check_eq("c_ren", 32'(bus.o_mem_ren), 32'h1);
    next_cycle();
    drive(1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("c2_if_gnt", 32'(bus.o_if_gnt), 32'h1);
    check_eq("c2_addr", bus.o_mem_addr, 32'h10);
    check_eq("c_d_rvalid", 32'(bus.o_d_rvalid), 32'h1);
    check_eq("c_d_rdata", bus.o_d_rdata, 32'hCAFE_0200);
    check_eq("c_if_rvalid0", 32'(bus.o_if_rvalid), 32'h0);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("c_if_rvalid", 32'(bus.o_if_rvalid), 32'h1);
    check_eq("c_if_rdata", bus.o_if_rdata, 32'h00A0_0093);
    check_eq("c_d_rvalid_off", 32'(bus.o_d_rvalid), 32'h0);
    next_cycle();

    // Masked data write, then read it back
    drive(1'b0, 32'h0, 1'b1, 1'b1, 32'h104, 32'hDEAD_BEEF, 4'h3);
    check_eq("w_gnt", 32'(bus.o_d_gnt), 32'h1);
    check_eq("w_wen", 32'(bus.o_mem_wen), 32'h1);
    check_eq("w_ren", 32'(bus.o_mem_ren), 32'h0);
    check_eq("w_addr", bus.o_mem_addr, 32'h104);
    check_eq("w_mask", 32'(bus.o_mem_mask), 32'h3);
    check_eq("w_wdata", bus.o_mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    drive(1'b0, 32'h0, 1'b1, 1'b0, 32'h104, 32'h0, 4'h0);
    check_eq("w_if_rvalid", 32'(bus.o_if_rvalid), 32'h0);
    check_eq("w_d_rvalid", 32'(bus.o_d_rvalid), 32'h0);
    next_cycle();
    drive(1'b1, 32'h7, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("rb_d_rdata", bus.o_d_rdata, 32'h0000_BEEF);
    check_eq("ua_addr", bus.o_mem_addr, 32'h4);
    check_eq("ua_gnt", 32'(bus.o_if_gnt), 32'h1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("ua_rdata", bus.o_if_rdata, 32'h93);
    next_cycle();

    // Both requesters held continuously
    drive(1'b1, 32'h0, 1'b1, 1'b0, 32'h200, 32'h0, 4'h0);
    for (int k = 0; k < 20; k++) begin
      logic exp_if;
`ifdef ARB_STARVE_GUARD_EN
      exp_if = ((k % 5) == 4);
`else
      exp_if = 1'b0;
`endif
      check_eq($sformatf("st%0d_if_gnt", k), 32'(bus.o_if_gnt), 32'(exp_if));
      check_eq($sformatf("st%0d_d_gnt", k), 32'(bus.o_d_gnt), 32'(!exp_if));
      next_cycle();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    next_cycle();

    // Reset pulsed while a fetch read is pending
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("rr_gnt", 32'(bus.o_if_gnt), 32'h1);
    next_cycle();
    check_eq("rr_rvalid_pre", 32'(bus.o_if_rvalid), 32'h1);
    #1 i_rst_n = 1'b0;
    #1;
    check_eq("rr_rvalid_drop", 32'(bus.o_if_rvalid), 32'h0);
    check_eq("rr_gnt_rst", 32'(bus.o_if_gnt), 32'h0);
    check_eq("rr_ren_rst", 32'(bus.o_mem_ren), 32'h0);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    i_rst_n = 1'b1;
    next_cycle();
    check_eq("rr_idle_rvalid", 32'(bus.o_if_rvalid), 32'h0);
    check_eq("rr_idle_rdata", bus.o_if_rdata, 32'h0);
    drive(1'b1, 32'h8, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("rr_post_gnt", 32'(bus.o_if_gnt), 32'h1);
    next_cycle();
    drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    check_eq("rr_post_rvalid", 32'(bus.o_if_rvalid), 32'h1);
    check_eq("rr_post_rdata", bus.o_if_rdata, 32'h113);
    next_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-port synchronous memory (1-cycle read latency) between the IF-stage instruction fetch and the MEM-stage data access. Grants at most one requester per cycle, drives the memory port from the winner, and routes the returning read data back to its owner. Denied requesters stall: the fetch side's `req && !gnt` feeds the PC stall input of the fetch stage. An optional anti-starvation guard bounds how long data traffic can block fetch.

## Interface
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles before fetch gets forced priority; legal range 1..15.

- `i_clk` in 1: global clock.
- `i_rst_n` in 1: asynchronous, active-low reset.
- `i_if_req` in 1: fetch read request.
- `i_if_addr` in 32: fetch byte address.
- `o_if_gnt` out 1: fetch accepted this cycle.
- `o_if_rvalid` out 1: `o_if_rdata` valid.
- `o_if_rdata` out 32: fetched word.
- `i_d_req` in 1: data request.
- `i_d_wen` in 1: 1 = write, 0 = read.
- `i_d_addr` in 32: data byte address.
- `i_d_wdata` in 32: write data.
- `i_d_mask` in 4: byte-enable mask for writes.
- `o_d_gnt` out 1: data access accepted this cycle.
- `o_d_rvalid` out 1: `o_d_rdata` valid.
- `o_d_rdata` out 32: read word.
- `o_mem_addr` out 32: memory address, with bits [1:0] forced to 0.
- `o_mem_ren` out 1: memory read strobe.
- `o_mem_wen` out 1: memory write strobe.
- `o_mem_wdata` out 32: memory write data.
- `o_mem_mask` out 4: memory byte mask.
- `i_mem_rdata` in 32: memory read data, valid 1 cycle after `o_mem_ren`.

## Operation
- Grants are combinational from the requests and the registered state.
- Default priority: data wins. If both request, `o_d_gnt` = 1 and `o_if_gnt` = 0.
- A lone request is always granted.
- The memory port mirrors the winner's signals.
  - Fetch win: `o_mem_ren` = 1, `o_mem_wen` = 0.
  - Data win: `o_mem_ren` = `!i_d_wen`, `o_mem_wen` = `i_d_wen`.
  - Idle: addr, wdata and mask are 0; both strobes are 0.
- Response FSM, registered:
  - States: IDLE, IF_RD, D_RD.
  - Next state is IF_RD after a fetch grant, D_RD after a data read grant.
  - Next state is IDLE after a data write grant or no grant.
  - Any state can move to any state every cycle.
- Response outputs:
  - In IF_RD: `o_if_rvalid` = 1 and `o_if_rdata` = `i_mem_rdata`.
  - In D_RD: `o_d_rvalid` = 1 and `o_d_rdata` = `i_mem_rdata`.
  - In other states, rvalid is 0 and rdata is 0.
- Requesters hold their request and payload stable until granted. The arbiter does not latch un-granted requests.
- Writes produce no rvalid.

## Timing
- Reset (async, `i_rst_n` = 0):
  - FSM goes to IDLE and the starve counter clears to 0.
  - All grants, strobes and rvalids are 0 while reset is asserted, regardless of requests.
- Grant latency is 0 cycles (same cycle as the request). Read data returns exactly 1 cycle after the grant.
- Back-to-back grants are allowed every cycle. A grant may coexist with the previous grant's rvalid, to the same or the other requester.
- Reset asserted mid-read: the pending rvalid is dropped and is not delivered after reset release.
- Reset release: grants may assert in the first cycle after `i_rst_n` rises.

## Configuration
- Macro: `ARB_STARVE_GUARD_EN`.
- Defined:
  - A 4-bit counter increments, saturating at `STARVE_LIMIT`, each cycle with `i_if_req && !o_if_gnt`.
  - It clears on a fetch grant or when `i_if_req` = 0.
  - When the counter equals `STARVE_LIMIT` and both requests are present, fetch wins. The counter then clears and data is denied that cycle.
- Undefined:
  - The counter is absent and data always wins. Fetch may starve indefinitely.

## Test plan
- Fetch-only stream at addresses 0x0, 0x4, 0x8 with mem returning 0x13, 0x93, 0x113 → `o_if_gnt` = 1 each cycle; `o_if_rvalid` = 1 one cycle later with matching data; `o_d_rvalid` = 0 throughout.
- Same-cycle fetch 0x10 and data read 0x200 → `o_d_gnt` = 1, `o_if_gnt` = 0, `o_mem_addr` = 0x200. The next cycle fetch is granted and `o_d_rvalid` = 1 with the 0x200 data.
- Data write (addr 0x104, wdata 0xDEADBEEF, mask 0x3) → `o_mem_wen` = 1, `o_mem_addr` = 0x104, `o_mem_mask` = 0x3; next cycle both rvalids = 0.
- With `ARB_STARVE_GUARD_EN` and `STARVE_LIMIT` = 4: both requests held continuously → fetch granted on cycle 5 only, then data wins the next 4 cycles; the pattern repeats. Without the macro → fetch is never granted.
- `i_rst_n` pulsed low mid-cycle the cycle after a fetch grant → `o_if_rvalid` drops to 0 immediately; FSM is IDLE after release; the first post-reset fetch returns data 1 cycle after its grant.
- Unaligned fetch address 0x7 → `o_mem_addr` = 0x4.
